// File: rtl/menu_pkg.sv
// Shared definitions for the game's top-level menu: screen codes, key
// bit positions and masks, and the single-key qualifier.
package menu_pkg;

  // The screen code doubles as the state encoding of the menu FSM.
  typedef enum logic [1:0] {
    SCR_GAME  = 2'b00,
    SCR_TITLE = 2'b01,
    SCR_CTRL  = 2'b10,
    SCR_CAR   = 2'b11
  } screen_e;

  localparam int KEY_W   = 6;
  localparam int K_UP    = 0;
  localparam int K_DOWN  = 1;
  localparam int K_LEFT  = 2;
  localparam int K_RIGHT = 3;
  localparam int K_ENTER = 4;
  localparam int K_ESC   = 5;

  localparam logic [KEY_W-1:0] KEY_UP_M    = 6'b000001;
  localparam logic [KEY_W-1:0] KEY_DOWN_M  = 6'b000010;
  localparam logic [KEY_W-1:0] KEY_LEFT_M  = 6'b000100;
  localparam logic [KEY_W-1:0] KEY_RIGHT_M = 6'b001000;
  localparam logic [KEY_W-1:0] KEY_ENTER_M = 6'b010000;
  localparam logic [KEY_W-1:0] KEY_ESC_M   = 6'b100000;

  // True when exactly one bit of v is set.
  function automatic logic one_hot(input logic [KEY_W-1:0] v);
    return (v != '0) && ((v & (v - 1'b1)) == '0);
  endfunction

endpackage

// File: rtl/key_edge_detect.sv
// Rising-edge detector for a vector of level inputs. History resets to
// all ones so a level already high when reset releases is not an edge.
module key_edge_detect #(
  parameter int W = 7
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] din,
  output logic [W-1:0] rise
);

  logic [W-1:0] prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) prev_q <= '1;
    else        prev_q <= din;
  end

  assign rise = din & ~prev_q;

endmodule

// File: rtl/menu_select_fsm.sv
// Top-level menu sequencer: TITLE -> CAR_SELECT -> CONTROL_SELECT -> GAME
// with ESC back-navigation, wrap-around selection arrow and lap-timer start.
module menu_select_fsm
  import menu_pkg::*;
#(
  parameter int N_CARS     = 4,
  parameter int N_CONTROLS = 2,
  parameter int IDX_W      = 3,
  parameter int CAR_X0     = 208,
  parameter int CAR_DX     = 192,
  parameter int CAR_Y      = 480,
  parameter int CTRL_X0    = 256,
  parameter int CTRL_DX    = 384,
  parameter int CTRL_Y     = 576
) (
  input  logic             pclk,
  input  logic             rst,
  input  logic [5:0]       key,
  input  logic             any_key,
  output logic [1:0]       screen,
  output logic             arrow_visible,
  output logic [10:0]      arrow_xpos,
  output logic [10:0]      arrow_ypos,
  output logic [IDX_W-1:0] car_sel,
  output logic [IDX_W-1:0] control_sel,
  output logic             sel_valid,
  output logic             lap_timer_start,
  output logic             game_active
);

  localparam logic [IDX_W-1:0] CAR_LAST  = IDX_W'(N_CARS - 1);
  localparam logic [IDX_W-1:0] CTRL_LAST = IDX_W'(N_CONTROLS - 1);

  function automatic logic [10:0] pos(input int base, input int pitch,
                                      input logic [IDX_W-1:0] idx);
    return 11'(base + int'(idx) * pitch);
  endfunction

  logic [KEY_W-1:0] press;
  logic [KEY_W-1:0] key_evt;
  logic             any_evt;

  key_edge_detect #(.W(KEY_W + 1)) u_edge (
    .clk   (pclk),
    .rst_n (rst),
    .din   ({any_key, key}),
    .rise  ({any_evt, press})
  );

  // Chords are discarded as a whole rather than resolved by priority.
  assign key_evt = one_hot(press) ? press : '0;

  screen_e          state_q, state_d;
  logic [IDX_W-1:0] cursor_q, cursor_d;
  logic [IDX_W-1:0] car_q, car_d;
  logic [IDX_W-1:0] ctrl_q, ctrl_d;
  logic             valid_q, valid_d;
  logic             lap_q, lap_d;
  logic             vis_q, vis_d;
  logic [10:0]      x_q, x_d;
  logic [10:0]      y_q, y_d;
  logic             game_q, game_d;

  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) begin
      state_q  <= SCR_TITLE;
      cursor_q <= '0;
      car_q    <= '0;
      ctrl_q   <= '0;
      valid_q  <= 1'b0;
      lap_q    <= 1'b0;
      vis_q    <= 1'b0;
      x_q      <= '0;
      y_q      <= '0;
      game_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cursor_q <= cursor_d;
      car_q    <= car_d;
      ctrl_q   <= ctrl_d;
      valid_q  <= valid_d;
      lap_q    <= lap_d;
      vis_q    <= vis_d;
      x_q      <= x_d;
      y_q      <= y_d;
      game_q   <= game_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cursor_d = cursor_q;
    car_d    = car_q;
    ctrl_d   = ctrl_q;
    valid_d  = valid_q;
    lap_d    = 1'b0;

    case (state_q)
      SCR_TITLE: begin
        if (any_evt) begin
          state_d  = SCR_CAR;
          cursor_d = '0;
          valid_d  = 1'b0;
        end
      end
      SCR_CAR: begin
        if (key_evt[K_RIGHT]) begin
          cursor_d = (cursor_q == CAR_LAST) ? '0 : cursor_q + 1'b1;
        end else if (key_evt[K_LEFT]) begin
          cursor_d = (cursor_q == '0) ? CAR_LAST : cursor_q - 1'b1;
        end else if (key_evt[K_ENTER]) begin
          car_d    = cursor_q;
          cursor_d = valid_q ? ctrl_q : '0;
          state_d  = SCR_CTRL;
        end else if (key_evt[K_ESC]) begin
          state_d = SCR_TITLE;
        end
      end
      SCR_CTRL: begin
        if (key_evt[K_RIGHT]) begin
          cursor_d = (cursor_q == CTRL_LAST) ? '0 : cursor_q + 1'b1;
        end else if (key_evt[K_LEFT]) begin
          cursor_d = (cursor_q == '0) ? CTRL_LAST : cursor_q - 1'b1;
        end else if (key_evt[K_ENTER]) begin
          ctrl_d  = cursor_q;
          valid_d = 1'b1;
          lap_d   = 1'b1;
          state_d = SCR_GAME;
        end else if (key_evt[K_ESC]) begin
          cursor_d = car_q;
          state_d  = SCR_CAR;
        end
      end
      SCR_GAME: begin
        if (key_evt[K_ESC]) state_d = SCR_TITLE;
      end
      default: state_d = SCR_TITLE;
    endcase
  end

  // Display outputs are derived from next-state values so they change on
  // the same edge that samples the key event.
  always_comb begin
    vis_d  = 1'b0;
    x_d    = '0;
    y_d    = '0;
    game_d = (state_d == SCR_GAME);
    case (state_d)
      SCR_CAR: begin
        vis_d = 1'b1;
        x_d   = pos(CAR_X0, CAR_DX, cursor_d);
        y_d   = 11'(CAR_Y);
      end
      SCR_CTRL: begin
        vis_d = 1'b1;
        x_d   = pos(CTRL_X0, CTRL_DX, cursor_d);
        y_d   = 11'(CTRL_Y);
      end
      default: ;
    endcase
  end

  assign screen          = state_q;
  assign arrow_visible   = vis_q;
  assign arrow_xpos      = x_q;
  assign arrow_ypos      = y_q;
  assign car_sel         = car_q;
  assign control_sel     = ctrl_q;
  assign sel_valid       = valid_q;
  assign lap_timer_start = lap_q;
  assign game_active     = game_q;

endmodule

// File: tb/tb_menu_select_fsm.sv
// Bench for menu_select_fsm: directed walk through the menu flow plus
// randomized key traffic, checked cycle by cycle against a screen-level model.
module tb_menu_select_fsm;

  localparam int N_CARS = 4, N_CONTROLS = 2, IDX_W = 3;
  localparam int CAR_X0 = 208, CAR_DX = 192, CAR_Y = 480;
  localparam int CTRL_X0 = 256, CTRL_DX = 384, CTRL_Y = 576;
  localparam int EW = 34;

  localparam logic [5:0] UP = 6'd1, DOWN = 6'd2, LEFT = 6'd4, RIGHT = 6'd8;
  localparam logic [5:0] ENTER = 6'd16, ESC = 6'd32;

  // model screens: 0 title, 1 car, 2 control, 3 game
  localparam int S_TITLE = 0, S_CAR = 1, S_CTRL = 2, S_GAME = 3;

  logic             pclk = 1'b0;
  logic             rst;
  logic [5:0]       key;
  logic             any_key;
  logic [1:0]       screen;
  logic             arrow_visible;
  logic [10:0]      arrow_xpos, arrow_ypos;
  logic [IDX_W-1:0] car_sel, control_sel;
  logic             sel_valid, lap_timer_start, game_active;

  always #5 pclk = ~pclk;

  menu_select_fsm #(
    .N_CARS(N_CARS), .N_CONTROLS(N_CONTROLS), .IDX_W(IDX_W),
    .CAR_X0(CAR_X0), .CAR_DX(CAR_DX), .CAR_Y(CAR_Y),
    .CTRL_X0(CTRL_X0), .CTRL_DX(CTRL_DX), .CTRL_Y(CTRL_Y)
  ) dut (
    .pclk(pclk), .rst(rst), .key(key), .any_key(any_key),
    .screen(screen), .arrow_visible(arrow_visible),
    .arrow_xpos(arrow_xpos), .arrow_ypos(arrow_ypos),
    .car_sel(car_sel), .control_sel(control_sel), .sel_valid(sel_valid),
    .lap_timer_start(lap_timer_start), .game_active(game_active)
  );

  int n_cmp = 0;
  int n_bad = 0;
  logic [EW-1:0] exp_q[$];

  int         m_scr, m_cur, m_car, m_ctrl;
  bit         m_valid, m_lap, m_aprev;
  logic [5:0] m_kprev;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_scr = S_TITLE; m_cur = 0; m_car = 0; m_ctrl = 0;
    m_valid = 0; m_lap = 0; m_kprev = 6'h3f; m_aprev = 1;
  endfunction

  function automatic void model_step(input logic [5:0] k, input logic a);
    logic [5:0] p;
    bit ae;
    p = k & ~m_kprev;
    ae = a && !m_aprev;
    m_kprev = k;
    m_aprev = a;
    m_lap = 0;
    if ($countones(p) != 1) p = 0;
    case (m_scr)
      S_TITLE: if (ae) begin m_scr = S_CAR; m_cur = 0; m_valid = 0; end
      S_CAR: begin
        if (p == RIGHT) m_cur = (m_cur + 1) % N_CARS;
        else if (p == LEFT) m_cur = (m_cur + N_CARS - 1) % N_CARS;
        else if (p == ENTER) begin
          m_car = m_cur; m_cur = m_valid ? m_ctrl : 0; m_scr = S_CTRL;
        end else if (p == ESC) m_scr = S_TITLE;
      end
      S_CTRL: begin
        if (p == RIGHT) m_cur = (m_cur + 1) % N_CONTROLS;
        else if (p == LEFT) m_cur = (m_cur + N_CONTROLS - 1) % N_CONTROLS;
        else if (p == ENTER) begin
          m_ctrl = m_cur; m_valid = 1; m_lap = 1; m_scr = S_GAME;
        end else if (p == ESC) begin m_cur = m_car; m_scr = S_CAR; end
      end
      default: if (p == ESC) m_scr = S_TITLE;
    endcase
  endfunction

  function automatic logic [EW-1:0] model_expect();
    int code[4] = '{1, 3, 2, 0};
    int x, y;
    bit vis;
    vis = (m_scr == S_CAR) || (m_scr == S_CTRL);
    x = 0; y = 0;
    if (m_scr == S_CAR)  begin x = (CAR_X0 + m_cur * CAR_DX) % 2048;   y = CAR_Y;  end
    if (m_scr == S_CTRL) begin x = (CTRL_X0 + m_cur * CTRL_DX) % 2048; y = CTRL_Y; end
    return {2'(code[m_scr]), vis, 11'(x), 11'(y), 3'(m_car), 3'(m_ctrl),
            m_valid, m_lap, (m_scr == S_GAME)};
  endfunction

  task automatic check_outputs();
    logic [EW-1:0] e;
    e = exp_q.pop_front();
    check("screen",          32'(screen),          32'(e[33:32]));
    check("arrow_visible",   32'(arrow_visible),   32'(e[31]));
    check("arrow_xpos",      32'(arrow_xpos),      32'(e[30:20]));
    check("arrow_ypos",      32'(arrow_ypos),      32'(e[19:9]));
    check("car_sel",         32'(car_sel),         32'(e[8:6]));
    check("control_sel",     32'(control_sel),     32'(e[5:3]));
    check("sel_valid",       32'(sel_valid),       32'(e[2]));
    check("lap_timer_start", 32'(lap_timer_start), 32'(e[1]));
    check("game_active",     32'(game_active),     32'(e[0]));
  endtask

  // Apply inputs after a falling edge, advance one rising edge, compare.
  task automatic cycle(input logic [5:0] k, input logic a);
    key = k;
    any_key = a;
    @(posedge pclk);
    if (rst) model_step(k, a);
    else     model_reset();
    exp_q.push_back(model_expect());
    @(negedge pclk);
    check_outputs();
  endtask

  task automatic tap(input logic [5:0] k);
    cycle(k, k != 0);
    cycle(6'd0, 1'b0);
  endtask

  task automatic async_reset_check();
    rst = 1'b0;
    #1;
    model_reset();
    exp_q.push_back(model_expect());
    check_outputs();
  endtask

  initial begin
    logic [5:0] k;
    logic a;
    int r;
    rst = 1'b1;
    key = ENTER;
    any_key = 1'b1;
    #1;
    async_reset_check();
    cycle(ENTER, 1'b1);
    rst = 1'b1;
    repeat (3) cycle(ENTER, 1'b1);
    check("held_through_reset", 32'(screen), 32'd1);
    cycle(6'd0, 1'b0);

    cycle(6'd0, 1'b1);
    check("title_exit_scr", 32'(screen), 32'd3);
    check("title_exit_x", 32'(arrow_xpos), 32'd208);
    cycle(6'd0, 1'b0);
    tap(LEFT);
    check("left_wrap_x", 32'(arrow_xpos), 32'd784);
    tap(RIGHT);
    tap(RIGHT);
    check("right_twice_x", 32'(arrow_xpos), 32'd400);
    tap(RIGHT);
    cycle(ENTER, 1'b1);
    check("enter_car_sel", 32'(car_sel), 32'd2);
    check("ctrl_arrow_y", 32'(arrow_ypos), 32'd576);
    cycle(6'd0, 1'b0);
    tap(RIGHT);
    check("ctrl_right_x", 32'(arrow_xpos), 32'd640);
    cycle(ENTER, 1'b1);
    check("lap_pulse", 32'(lap_timer_start), 32'd1);
    cycle(ENTER, 1'b1);
    check("lap_one_cycle", 32'(lap_timer_start), 32'd0);
    cycle(6'd0, 1'b0);
    tap(ESC);
    check("game_esc_car_kept", 32'(car_sel), 32'd2);
    cycle(6'd0, 1'b1);
    check("sel_valid_cleared", 32'(sel_valid), 32'd0);
    cycle(6'd0, 1'b0);

    repeat (50) cycle(RIGHT, 1'b1);
    check("hold_one_step_x", 32'(arrow_xpos), 32'd400);
    cycle(6'd0, 1'b0);
    cycle(LEFT | RIGHT, 1'b1);
    check("chord_ignored_x", 32'(arrow_xpos), 32'd400);
    cycle(6'd0, 1'b0);
    tap(ENTER);
    tap(ESC);
    check("ctrl_esc_cursor_x", 32'(arrow_xpos), 32'd400);
    tap(ENTER);

    key = ENTER;
    any_key = 1'b1;
    #2;
    async_reset_check();
    cycle(ENTER, 1'b1);
    check("reset_no_lap", 32'(lap_timer_start), 32'd0);
    rst = 1'b1;
    cycle(6'd0, 1'b0);

    for (int i = 0; i < 3000; i++) begin
      r = $urandom_range(0, 99);
      if (r < 2) begin
        async_reset_check();
        cycle(6'($urandom), 1'($urandom));
        rst = 1'b1;
      end else begin
        r = $urandom_range(0, 99);
        if (r < 40)      k = 6'd0;
        else if (r < 85) k = 6'(1 << $urandom_range(0, 5));
        else             k = 6'($urandom);
        a = (k != 0);
        if ($urandom_range(0, 9) == 0) a = ~a;
        cycle(k, a);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/menu_select_fsm.md
Name: menu_select_fsm

Overview:
- Parametrised successor to the game's top-level menu state machine.
- Sequences the screens TITLE -> CAR_SELECT -> CONTROL_SELECT -> GAME, with ESC back-navigation.
- Moves a selection arrow with bidirectional wrap-around over N_CARS / N_CONTROLS items and latches the chosen car and control mode.
- Sits between the keyboard decoder and the sprite/background renderers; issues a one-cycle lap-timer start pulse on entry to GAME.

Parameters:
- N_CARS, 4, number of selectable cars (2..2**IDX_W).
- N_CONTROLS, 2, number of selectable control modes (2..2**IDX_W).
- IDX_W, 3, width of cursor and selection indices.
- CAR_X0, 208, arrow x for car item 0.
- CAR_DX, 192, x pitch between car items.
- CAR_Y, 480, arrow y on the car screen.
- CTRL_X0, 256, arrow x for control item 0.
- CTRL_DX, 384, x pitch between control items.
- CTRL_Y, 576, arrow y on the control screen.

Ports:
- pclk  input  1  pixel clock; all logic on rising edge.
- rst  input  1  reset, asynchronous, active-low (asserted when 0).
- key  input  6  level key vector {ESC,ENTER,RIGHT,LEFT,DOWN,UP}, bit5..bit0.
- any_key  input  1  high while any keycode is nonzero.
- screen  output  2  TITLE=01, CAR_SELECT=11, CONTROL_SELECT=10, GAME=00.
- arrow_visible  output  1  arrow sprite enable.
- arrow_xpos  output  11  arrow x position.
- arrow_ypos  output  11  arrow y position.
- car_sel  output  IDX_W  latched car index.
- control_sel  output  IDX_W  latched control index.
- sel_valid  output  1  both selections committed since last TITLE.
- lap_timer_start  output  1  one-cycle pulse on GAME entry.
- game_active  output  1  high in GAME.

Behaviour:

Reset values:
- screen=01, all other outputs 0, cursor=0.
- key_prev=6'b111111 and any_prev=1, so a key held through reset release produces no event.

Event detection:
- press = key & ~key_prev; key_prev <= key every cycle.
- A press is acted on only if exactly one bit is set; multi-bit presses are ignored entirely.
- any_evt = any_key & ~any_prev.

Timing:
- All outputs are registered from next-state values, so they reflect an event at the same edge the event is sampled.
- Holding a key generates exactly one event.

TITLE:
- any_evt -> CAR_SELECT; cursor <= 0; sel_valid <= 0.
- Individual key events are ignored (any_evt alone drives the transition).

CAR_SELECT:
- RIGHT: cursor+1, wrapping N_CARS-1 -> 0.
- LEFT: cursor-1, wrapping 0 -> N_CARS-1.
- ENTER: car_sel <= cursor; cursor <= control_sel if sel_valid, else 0; -> CONTROL_SELECT.
- ESC -> TITLE. UP/DOWN are ignored.
- arrow_visible=1, arrow_xpos=CAR_X0+cursor*CAR_DX, arrow_ypos=CAR_Y.

CONTROL_SELECT:
- LEFT/RIGHT wrap over N_CONTROLS exactly as above.
- ENTER: control_sel <= cursor; sel_valid <= 1; lap_timer_start=1 for that single cycle; -> GAME.
- ESC: -> CAR_SELECT with cursor <= car_sel.
- arrow_xpos=CTRL_X0+cursor*CTRL_DX, arrow_ypos=CTRL_Y.

GAME:
- game_active=1, arrow_visible=0.
- ESC -> TITLE; car_sel/control_sel are retained, sel_valid is cleared on the next TITLE exit.
- All other keys are ignored.

Arithmetic and state encoding:
- Position math is computed at 11 bits and truncated; parameters must keep results below 2048.
- The state register uses the screen encoding directly. Any illegal state recovers to TITLE on the next edge.

Reset and simultaneity:
- Reset mid-operation returns immediately (asynchronously) to reset values. lap_timer_start must deassert with no further pulse.
- Simultaneous any_evt and key event in TITLE: only the transition occurs; no cursor movement.

Decomposition:
- menu_pkg holds the screen codes, key bit indices/masks, and the ONE_HOT check function.
- Sub-module key_edge_detect (parametrised width, async active-low reset, reset-to-ones) produces press and any_evt.
- Position multiply is by constant parameters; no separate arithmetic block is needed.

Test Plan:
- Reset with key=ENTER held, then release rst -> no transition; screen=01 and all outputs 0.
- TITLE, any_key rises -> screen=11, arrow (208,480). LEFT press -> cursor 3, arrow (784,480). RIGHT twice -> cursor 1, arrow (400,480).
- From CAR_SELECT cursor 2, ENTER -> car_sel=2, screen=10, arrow (256,576). RIGHT -> (640,576). ENTER -> control_sel=1, sel_valid=1, lap_timer_start high exactly one cycle, game_active=1.
- Hold RIGHT for 50 cycles in CAR_SELECT -> cursor advances by exactly 1. LEFT+RIGHT pressed in the same cycle -> no change.
- CONTROL_SELECT ESC -> screen=11, cursor=car_sel. GAME ESC -> screen=01, car_sel retained. Then any_key -> sel_valid=0.
- Assert rst in CONTROL_SELECT during ENTER edge -> no lap_timer_start pulse; screen=01 immediately.
